// File: rtl/sha_pkg.sv
// sha_pkg: shared constants and types for the SHA-256 round controller.
// Holds the K round constants, the H0 initial hash and the FSM state type.
package sha_pkg;

  localparam int ROUND_W = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [255:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_lookup(
    input logic [ROUND_W-1:0] idx
  );
    return K[idx];
  endfunction

endpackage

// File: rtl/sha_round_ctrl_feedforward.sv
// sha_feedforward: per-word mod-2^32 add of base hash and work vars.
// Carries never cross 32-bit word boundaries.
module sha_feedforward (
  input  logic [255:0] base_i,
  input  logic [255:0] work_i,
  output logic [255:0] sum_o
);

  for (genvar i = 0; i < 8; i++) begin : g_word
    assign sum_o[32*i +: 32] =
      base_i[32*i +: 32] + work_i[32*i +: 32];
  end

endmodule

// File: rtl/sha_round_ctrl.sv
// sha_round_ctrl: SHA-256 block sequencer.
// Load -> stallable rounds -> feed-forward -> digest handshake.
module sha_round_ctrl
  import sha_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         chain,
  input  logic [255:0] init_hash,
  input  logic         w_valid,
  input  logic [255:0] work_vars,
  output logic         ready,
  output logic         load_hash,
  output logic [255:0] hash_out,
  output logic         round_en,
  output logic [5:0]   round_idx,
  output logic [31:0]  k_i,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready
);

  localparam logic [ROUND_W-1:0] LAST =
    ROUND_W'(ROUNDS - 1);

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] idx_q, idx_d;
  logic [255:0]       base_q, base_d;
  logic [255:0]       digest_q, digest_d;
  logic [255:0]       ff_sum;

  sha_feedforward u_ff (
    .base_i (base_q),
    .work_i (work_vars),
    .sum_o  (ff_sum)
  );

  // Next-state: sequence one block, hold on schedule stalls.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    base_d   = base_q;
    digest_d = digest_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = chain ? digest_q : init_hash;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        idx_d   = '0;
        state_d = ROUND;
      end
      ROUND: begin
        if (w_valid) begin
          if (idx_q == LAST) begin
            state_d = FINAL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FINAL: begin
        digest_d = ff_sum;
        state_d  = DONE;
      end
      DONE: begin
        if (digest_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      base_q   <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      digest_q <= digest_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign load_hash    = (state_q == LOAD);
  assign round_en     = (state_q == ROUND) && w_valid;
  assign digest_valid = (state_q == DONE);
  assign hash_out     = base_q;
  assign round_idx    = idx_q;
  assign k_i          = k_lookup(idx_q);
  assign digest       = digest_q;

  a_excl: assert property (
    @(posedge clk) disable iff (rst)
    !(load_hash && round_en)
  );

  a_idx: assert property (
    @(posedge clk) disable iff (rst)
    round_idx <= 6'(ROUNDS - 1)
  );

endmodule

// File: tb/tb_sha_round_ctrl.sv
// tb_sha_round_ctrl: randomized bench with SHA-256 datapath model.
// Per-cycle timeline expectations plus reference digests.
module tb_sha_round_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, chain, w_valid, digest_ready;
  logic [255:0] init_hash, work_vars, hash_out, digest;
  logic         ready, load_hash, round_en, digest_valid;
  logic [5:0]   round_idx;
  logic [31:0]  k_i;

  int checks = 0;
  int failures = 0;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam bit [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    bit           en;
    string        tag;
    bit           rdy;
    bit           ld;
    bit           ren;
    bit           dv;
    bit           chk_idx;
    logic [5:0]   idx;
    bit           chk_dig;
    logic [255:0] dig;
    bit           chk_hash;
    logic [255:0] hsh;
  } exp_t;

  exp_t         cur;
  logic [31:0]  W [64];
  logic [255:0] wv;
  logic [255:0] ref_prev;
  int           stall_n [64];

  sha_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .chain        (chain),
    .init_hash    (init_hash),
    .w_valid      (w_valid),
    .work_vars    (work_vars),
    .ready        (ready),
    .load_hash    (load_hash),
    .hash_out     (hash_out),
    .round_en     (round_en),
    .round_idx    (round_idx),
    .k_i          (k_i),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(
    input logic [31:0] x, input int n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] rnd(
    input logic [255:0] s,
    input logic [31:0] k,
    input logic [31:0] w
  );
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
       + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
       + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic void sched(input logic [511:0] blk);
    logic [31:0] x, y;
    for (int t = 0; t < 16; t++) W[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      x = W[t-15];
      y = W[t-2];
      W[t] = (rotr(y, 17) ^ rotr(y, 19) ^ (y >> 10)) + W[t-7]
           + (rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3)) + W[t-16];
    end
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] b);
    logic [255:0] s, o;
    s = b;
    for (int t = 0; t < 64; t++) s = rnd(s, KT[t], W[t]);
    for (int i = 0; i < 8; i++)
      o[32*i +: 32] = b[32*i +: 32] + s[32*i +: 32];
    return o;
  endfunction

  // Datapath model: loads on load_hash, advances on round_en.
  always @(posedge clk) begin
    if (load_hash) wv <= hash_out;
    else if (round_en) wv <= rnd(wv, k_i, W[round_idx]);
  end
  assign work_vars = wv;

  task automatic chk(
    input string nm, input logic [255:0] act, input logic [255:0] req
  );
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Compare process: checks outputs against the cycle's expectation.
  always @(negedge clk) begin
    #1;
    if (cur.en) begin
      chk({cur.tag, ":ready"}, 256'(ready), 256'(cur.rdy));
      chk({cur.tag, ":load"}, 256'(load_hash), 256'(cur.ld));
      chk({cur.tag, ":round_en"}, 256'(round_en), 256'(cur.ren));
      chk({cur.tag, ":dvalid"}, 256'(digest_valid), 256'(cur.dv));
      if (cur.chk_idx) begin
        chk({cur.tag, ":idx"}, 256'(round_idx), 256'(cur.idx));
        chk({cur.tag, ":k"}, 256'(k_i), 256'(KT[cur.idx]));
        if (cur.idx == 6'd0)
          chk({cur.tag, ":k0"}, 256'(k_i), 256'(32'h428a2f98));
        if (cur.idx == 6'd63)
          chk({cur.tag, ":k63"}, 256'(k_i), 256'(32'hc67178f2));
      end
      if (cur.chk_dig) chk({cur.tag, ":digest"}, digest, cur.dig);
      if (cur.chk_hash) chk({cur.tag, ":hash"}, hash_out, cur.hsh);
    end
  end

  function automatic exp_t mk(
    input string tag, input bit r, input bit l, input bit e, input bit v
  );
    exp_t x;
    x = '{en: 1'b1, tag: tag, rdy: r, ld: l, ren: e, dv: v,
          chk_idx: 1'b0, idx: 6'd0, chk_dig: 1'b0, dig: '0,
          chk_hash: 1'b0, hsh: '0};
    return x;
  endfunction

  task automatic drive(
    input logic s, input logic ch, input logic [255:0] ih,
    input logic wvld, input logic dr, input logic r, input exp_t e
  );
    @(negedge clk);
    rst = r; start = s; chain = ch; init_hash = ih;
    w_valid = wvld; digest_ready = dr;
    cur = e;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_block(
    input string tag, input logic [511:0] blk, input bit ch,
    input logic [255:0] ih, input int hold, input int abort_r,
    input bit lit_en, input logic [255:0] lit
  );
    logic [255:0] base, expd;
    exp_t e;
    sched(blk);
    base = ch ? ref_prev : ih;
    expd = compress(base);
    if (lit_en) chk({tag, ":model"}, expd, lit);
    e = mk({tag, ":idle"}, 1, 0, 0, 0);
    drive(1, ch, ih, 0, 0, 0, e);
    e = mk({tag, ":load"}, 0, 1, 0, 0);
    e.chk_idx = 1; e.chk_hash = 1; e.hsh = base;
    drive(0, 0, rnd256(), 0, 0, 0, e);
    for (int r = 0; r < 64; r++) begin
      if (r == abort_r) begin
        e = mk({tag, ":abort"}, 0, 0, 0, 0);
        e.chk_idx = 1; e.idx = 6'(r);
        drive(0, 0, '0, 0, 0, 1, e);
        e = mk({tag, ":postrst"}, 1, 0, 0, 0);
        e.chk_idx = 1; e.chk_dig = 1; e.dig = '0;
        e.chk_hash = 1; e.hsh = '0;
        drive(0, 0, '0, 0, 0, 0, e);
        ref_prev = '0;
        return;
      end
      for (int s = 0; s < stall_n[r]; s++) begin
        e = mk({tag, ":stall"}, 0, 0, 0, 0);
        e.chk_idx = 1; e.idx = 6'(r);
        drive(1'($urandom), 0, '0, 0, 0, 0, e);
      end
      e = mk({tag, ":round"}, 0, 0, 1, 0);
      e.chk_idx = 1; e.idx = 6'(r);
      drive(0, 0, '0, 1, 1'($urandom), 0, e);
    end
    e = mk({tag, ":final"}, 0, 0, 0, 0);
    drive(1'($urandom), 0, '0, 1'($urandom), 1'($urandom), 0, e);
    for (int h = 0; h < hold; h++) begin
      e = mk({tag, ":hold"}, 0, 0, 0, 1);
      e.chk_dig = 1; e.dig = expd;
      drive(1'($urandom), 1'($urandom), rnd256(), 0, 0, 0, e);
    end
    e = mk({tag, ":accept"}, 0, 0, 0, 1);
    e.chk_dig = 1; e.dig = expd;
    drive(0, 0, '0, 0, 1, 0, e);
    ref_prev = expd;
  endtask

  task automatic clr_stalls();
    for (int r = 0; r < 64; r++) stall_n[r] = 0;
  endtask

  logic [511:0] abc_blk, two1_blk, two2_blk;
  logic [255:0] abc_dig, two_dig;

  initial begin
    exp_t e;
    cur.en = 0;
    rst = 1; start = 0; chain = 0; init_hash = '0;
    w_valid = 0; digest_ready = 0; wv = '0; ref_prev = '0;
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};
    two1_blk = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two2_blk = {480'd0, 32'h000001c0};
    abc_dig = {
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    two_dig = {
      32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
    clr_stalls();
    repeat (3) @(negedge clk);
    e = mk("reset", 1, 0, 0, 0);
    e.chk_idx = 1; e.chk_dig = 1; e.dig = '0;
    e.chk_hash = 1; e.hsh = '0;
    drive(0, 0, '0, 0, 0, 0, e);
    run_block("abc", abc_blk, 0, IV, 0, -1, 1, abc_dig);
    stall_n[0] = 1; stall_n[31] = 1; stall_n[63] = 1;
    run_block("stall", abc_blk, 0, IV, 1, -1, 1, abc_dig);
    clr_stalls();
    run_block("hs", abc_blk, 0, IV, 10, -1, 1, abc_dig);
    run_block("abort", abc_blk, 0, IV, 0, 20, 0, '0);
    run_block("fresh", abc_blk, 0, IV, 2, -1, 1, abc_dig);
    run_block("two1", two1_blk, 0, IV, 1, -1, 0, '0);
    run_block("two2", two2_blk, 1, rnd256(), 0, -1, 1, two_dig);
    for (int n = 0; n < 8; n++) begin
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      for (int r = 0; r < 64; r++)
        stall_n[r] = ($urandom_range(0, 7) == 0) ?
                     $urandom_range(1, 2) : 0;
      run_block("rand", b, 1'($urandom), rnd256(),
                $urandom_range(0, 3), -1, 0, '0);
    end
    e = mk("tail", 1, 0, 0, 0);
    drive(0, 0, '0, 0, 0, 0, e);
    @(negedge clk);
    #2;
    cur.en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/sha_round_ctrl.md
Name: sha_round_ctrl

Overview:
- Sequencing controller for the SHA-256 compression datapath.
- On a start request it does three things:
  - Drives the datapath's load strobe with the selected initial hash.
  - Steps 64 enabled rounds, supplying round index and K constant, with optional stall from the message-schedule block.
  - Performs the final per-word feed-forward addition.
- Presents the 256-bit digest under a valid/ready handshake.
- Supports chaining, so multi-block messages (e.g. 80-byte headers) reuse the previous digest as the next initial hash.

Parameters:
- ROUNDS, 64, number of compression rounds per block (fixed for SHA-256; the counter width derives from it).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request to process one block; accepted only when ready=1
- chain  in  1  sampled with start: 1 = use internal digest register as initial hash, 0 = use init_hash
- init_hash  in  256  initial hash when chain=0 (H0 in [255:224] ... H7 in [31:0])
- w_valid  in  1  schedule block has w_i for the current round_idx; 0 stalls the round
- work_vars  in  256  datapath working registers {a,b,c,d,e,f,g,h}, a in [255:224]
- ready  out  1  controller idle and able to accept start
- load_hash  out  1  one-cycle load strobe to datapath
- hash_out  out  256  hash value for datapath load; valid while load_hash=1
- round_en  out  1  datapath round enable
- round_idx  out  6  current round 0..63 (to schedule block)
- k_i  out  32  K[round_idx], combinational from package table
- digest  out  256  final hash; stable while digest_valid=1
- digest_valid  out  1  digest available
- digest_ready  in  1  consumer accepts digest

Behaviour:
- Reset values (rst=1 at clk edge): state IDLE, ready=1, load_hash=0, round_en=0, round_idx=0, digest_valid=0, digest=0, base register=0. Reset mid-operation aborts the block immediately; the datapath is not touched further.
- State IDLE:
  - ready=1.
  - If start=1: latch base = chain ? digest : init_hash; go to LOAD.
  - start while ready=0 is ignored (no queueing).
- State LOAD (1 cycle):
  - load_hash=1; hash_out = base; round_idx=0.
  - Go to ROUND.
- State ROUND:
  - round_en = w_valid.
  - On each edge with w_valid=1: if round_idx=63, go to FINAL; else round_idx increments.
  - With w_valid=0: round_idx and state hold and round_en=0 (datapath holds).
  - k_i always tracks round_idx.
- State FINAL (1 cycle):
  - digest[32i+31:32i] <= base word i + work_vars word i, mod 2^32 (carry discarded per word, no cross-word carry).
  - Go to DONE.
- State DONE:
  - digest_valid=1.
  - On digest_valid & digest_ready: go to IDLE (ready=1 next cycle). Digest register retains its value for later chaining.
- Latency with start at edge 0 and no stalls:
  - LOAD in cycle 1.
  - Rounds in cycles 2..65.
  - FINAL in cycle 66.
  - digest_valid=1 from cycle 67.
  - Each w_valid=0 cycle adds 1.
- Output constraints:
  - hash_out is driven with base in all states; only meaningful with load_hash.
  - load_hash and round_en are never both 1.
  - round_en=0 outside ROUND.
- Simultaneous events:
  - digest_ready=1 in the same cycle digest_valid rises completes the handshake that cycle.
  - start is not sampled in DONE.
- round_idx wrap: never exceeds 63; it resets to 0 in LOAD.

Decomposition:
- Package sha_pkg holds:
  - the K[0:63] 32-bit constant array;
  - the H0 initial hash constant;
  - the typedef for the state enum {IDLE, LOAD, ROUND, FINAL, DONE};
  - ROUND_W=6.
- One natural sub-module, sha_feedforward: combinational 8-word mod-2^32 adder (base + work_vars), instantiated once.

Test Plan:
- "abc" single block: controller + compressionSHA + bench W-model, chain=0, init_hash=H0 -> digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; digest_valid exactly 67 cycles after start.
- Stall: same block with w_valid=0 on rounds 0, 31, 63 (one cycle each) -> identical digest; digest_valid at 70 cycles; round_en=0 and round_idx held during each stall.
- Chaining: two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second start with chain=1 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Handshake: hold digest_ready=0 for 10 cycles after digest_valid -> digest stable, ready=0, start pulses ignored; digest_ready=1 -> ready=1 next cycle.
- Reset mid-block: assert rst during round 20 -> next cycle state IDLE, round_en=0, digest_valid=0, digest=0; a fresh "abc" run then produces the correct digest.
- K check: over a full run, k_i at round_idx=0 is 428a2f98 and at round_idx=63 is c67178f2; load_hash is high for exactly one cycle.
